// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg -- shared UART frame constants and receiver state encoding. Rev 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int DEFAULT_CLK_FREQ  = 10_000_000;
  localparam int DEFAULT_BAUD_RATE = 115_200;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_sync -- two-flop synchronizer for an asynchronous input. Rev 1.0
// ----------------------------------------------------------------------------
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver, mid-bit sampling, valid/ready holding register. Rev 1.0
// ----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE = DEFAULT_BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int SYMBOL_COUNT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_COUNT   = SYMBOL_COUNT / 2;
  localparam int CNT_W        = $clog2(SYMBOL_COUNT);
  localparam int BIT_W        = $clog2(DATA_BITS + STOP_BITS);

  localparam logic [CNT_W-1:0] SYM_LAST  = CNT_W'(SYMBOL_COUNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_COUNT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  rx_state_e            state_q,     state_d;
  logic [CNT_W-1:0]     clk_cnt_q,   clk_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q,   bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic [7:0]           rx_data_q,   rx_data_d;
  logic                 rx_valid_q,  rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q,   overrun_d;
  logic                 stop_good;

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q + 1'b1;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    stop_good   = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          // A line already back high at mid start bit was only a glitch.
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == SYM_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BIT_LAST) begin
            state_d = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (clk_cnt_q == SYM_LAST) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            stop_good = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        clk_cnt_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = ST_IDLE;
      end
    endcase

    // A consumer draining the register in the completion cycle makes room for the new byte.
    if (stop_good) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_rx -- directed and randomized frames against a line-level model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int SYM     = 10_000_000 / 115_200;
  localparam int HALF    = SYM / 2;
  // two synchronizer stages, IDLE detect cycle folded into HALF+1, then registered delivery
  localparam int LATENCY = 2 + 1 + HALF + 9 * SYM;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rx       = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  byte unsigned got_q[$];
  byte unsigned exp_q[$];
  int           fe_cnt     = 0;
  int           ov_cnt     = 0;
  int           rise_cyc   = -1;
  logic [7:0]   rise_data  = 8'h00;
  logic         valid_prev = 1'b0;
  int           start_cyc  = 0;
  int           fe0;
  int           ov0;

  uart_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs and the handshake just after the falling edge, once inputs have settled.
  always begin
    @(negedge clk);
    #1;
    if (rx_valid && !valid_prev) begin
      rise_cyc  = cyc;
      rise_data = rx_data;
    end
    valid_prev = rx_valid;
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, observed %0d cycles, required finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Line model: start bit, eight data bits LSB first, one stop bit, each `per` cycles long.
  task automatic send_byte(input logic [7:0] b, input int per, input logic stop_bit);
    logic [9:0] frame;
    frame     = {stop_bit, b, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (per) @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  rx_data,   32'h00);
    check({tag, "_valid"}, rx_valid,  32'h0);
    check({tag, "_ferr"},  frame_err, 32'h0);
    check({tag, "_ovr"},   overrun,   32'h0);
    check({tag, "_busy"},  busy,      32'h0);
  endtask

  initial begin
    byte unsigned msg[11];
    logic [7:0]   b;
    int           per;
    int           gap;
    int           n;

    msg = '{8'h50, 8'h68, 8'h69, 8'h6C, 8'h69, 8'h70, 8'h20, 8'h4D, 8'h6F, 8'h68, 8'h72};

    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte at nominal rate, check delivery latency.
    rx_ready = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt; rise_cyc = -1;
    got_q.delete();
    send_byte(8'h50, SYM, 1'b1);
    repeat (20) @(negedge clk);
    check("t1_latency", rise_cyc - start_cyc, LATENCY);
    check("t1_data", rise_data, 32'h50);
    check("t1_count", got_q.size(), 1);
    if (got_q.size() > 0) check("t1_got", got_q[0], 32'h50);
    check("t1_valid_drained", rx_valid, 32'h0);
    check("t1_busy", busy, 32'h0);
    check("t1_ferr", fe_cnt - fe0, 0);
    check("t1_ovr", ov_cnt - ov0, 0);

    // Back-to-back string at a slow line.
    got_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt;
    foreach (msg[i]) send_byte(msg[i], SYM + 1, 1'b1);
    repeat (20) @(negedge clk);
    check("t2_count", got_q.size(), 11);
    n = (got_q.size() < 11) ? got_q.size() : 11;
    for (int i = 0; i < n; i++) check($sformatf("t2_byte%0d", i), got_q[i], msg[i]);
    check("t2_ferr", fe_cnt - fe0, 0);
    check("t2_ovr", ov_cnt - ov0, 0);

    // Short low glitch on an idle line.
    got_q.delete();
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (12) @(negedge clk);
    check("t3_busy_during", busy, 32'h1);
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    check("t3_busy_after", busy, 32'h0);
    check("t3_valid", rx_valid, 32'h0);
    check("t3_count", got_q.size(), 0);
    check("t3_ferr", fe_cnt - fe0, 0);

    // Bad stop bit followed by a held-low line, then a clean frame.
    got_q.delete();
    fe0 = fe_cnt;
    send_byte(8'hA5, SYM, 1'b0);
    repeat (300) @(negedge clk);
    check("t4_ferr", fe_cnt - fe0, 1);
    check("t4_count", got_q.size(), 0);
    check("t4_valid", rx_valid, 32'h0);
    check("t4_busy_held", busy, 32'h1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("t4_busy_released", busy, 32'h0);
    send_byte(8'h3C, SYM, 1'b1);
    repeat (20) @(negedge clk);
    check("t4_count2", got_q.size(), 1);
    if (got_q.size() > 0) check("t4_got", got_q[0], 32'h3C);
    check("t4_ferr2", fe_cnt - fe0, 1);

    // Overrun while the consumer stalls.
    got_q.delete();
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    send_byte(8'h55, SYM, 1'b1);
    repeat (10) @(negedge clk);
    check("t5_valid1", rx_valid, 32'h1);
    check("t5_data1", rx_data, 32'h55);
    send_byte(8'hAA, SYM, 1'b1);
    repeat (10) @(negedge clk);
    check("t5_ovr", ov_cnt - ov0, 1);
    check("t5_data_held", rx_data, 32'h55);
    check("t5_valid2", rx_valid, 32'h1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    #1;
    check("t5_valid_drop", rx_valid, 32'h0);
    repeat (3) @(negedge clk);
    check("t5_count", got_q.size(), 1);
    if (got_q.size() > 0) check("t5_got", got_q[0], 32'h55);

    // Reset in the middle of a frame, with an older byte still pending.
    got_q.delete();
    send_byte(8'h77, SYM, 1'b1);
    repeat (10) @(negedge clk);
    check("t6_pending", rx_valid, 32'h1);
    fork
      send_byte(8'hC3, SYM, 1'b1);
      begin
        repeat (5 * SYM + HALF) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_in_reset");
      end
    join
    repeat (5) @(negedge clk);
    check_reset_outputs("t6_held_reset");
    rst_n = 1'b1;
    repeat (2 * SYM) @(negedge clk);
    check("t6_valid_after", rx_valid, 32'h0);
    check("t6_busy_after", busy, 32'h0);
    rx_ready = 1'b1;
    send_byte(8'h12, SYM, 1'b1);
    repeat (20) @(negedge clk);
    check("t6_count", got_q.size(), 1);
    if (got_q.size() > 0) check("t6_got", got_q[0], 32'h12);

    // Randomized bytes, rates within +/-1 cycle per bit, random idle gaps.
    got_q.delete();
    exp_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int k = 0; k < 10; k++) begin
      b   = 8'($urandom_range(0, 255));
      per = $urandom_range(SYM - 1, SYM + 1);
      gap = $urandom_range(0, 40);
      send_byte(b, per, 1'b1);
      exp_q.push_back(b);
      repeat (gap) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    check("rnd_count", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("rnd_byte%0d", i), got_q[i], exp_q[i]);
    check("rnd_ferr", fe_cnt - fe0, 0);
    check("rnd_ovr", ov_cnt - ov0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, 8N1, LSB first. It is the receiving counterpart of the design's UART transmitter.
- Recovers bytes from the asynchronous serial line `rx` by sampling at mid-bit.
- Presents each byte on a valid/ready holding register.
- Flags framing errors and overruns.
- Used for loopback checks of the credits transmitter and as the host-input path on the 10 MHz SUBLEQ/FRAM CPU platform.

Parameters:
- CLK_FREQ, 10000000: system clock frequency in Hz.
- BAUD_RATE, 115200: line baud rate.
- SYMBOL_COUNT, CLK_FREQ/BAUD_RATE (86): clock cycles per bit.
- HALF_COUNT, SYMBOL_COUNT/2 (43): cycles from start-edge detection to the start-bit sample.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  8  last accepted byte.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while holding register full.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchronizer flops=1, state=IDLE, counters=0, shift register=0x00.
- rx passes through a 2-flop synchronizer; all decisions use the synchronized value rx_s (2-cycle input latency).
- State machine: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: when rx_s==0 (cycle t0), clear clk_counter and go to START.
  - START: at t0+HALF_COUNT, sample rx_s.
    - If 0: go to DATA with bit_counter=0.
    - If 1: glitch; return to IDLE with no outputs.
  - DATA: bit n (n=0..7) is sampled at t0+HALF_COUNT+(n+1)*SYMBOL_COUNT.
    - Shift right; the sampled bit enters bit 7.
    - After bit 7, go to STOP.
  - STOP: sample at t0+HALF_COUNT+9*SYMBOL_COUNT.
    - If 1: frame is good; deliver the byte (see below) and go to IDLE.
    - If 0: pulse frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then go to IDLE. This prevents a break condition from being read as repeated 0x00 frames.
- clk_counter counts 0..SYMBOL_COUNT-1 between samples and wraps to 0 at each sample. Width is sufficient for SYMBOL_COUNT (32 bits permitted).
- Delivery, in the cycle after the stop sample:
  - rx_valid==0: load rx_data, set rx_valid=1.
  - rx_valid==1 && rx_ready==1 in that same cycle: load the new byte, rx_valid stays 1, no overrun.
  - rx_valid==1 && rx_ready==0: keep the old byte, drop the new one, pulse overrun.
- Handshake:
  - rx_valid falls in the cycle after rx_valid && rx_ready, unless a new byte is loaded in that same cycle.
  - rx_data is stable while rx_valid==1.
  - rx_ready is ignored while rx_valid==0.
- A new start bit is detected immediately after returning to IDLE, so back-to-back frames with a single stop bit are received.
- Tolerance: with ±1 cycle/bit period mismatch (85–87 cycles), accumulated drift at the stop sample is ≤9 cycles, within HALF_COUNT. Reception must succeed.
- Reset asserted mid-frame: all state and outputs return to reset values immediately. Any pending byte is lost. After release, reception resumes only on the next falling edge seen in IDLE.
- Timing: busy rises the cycle after t0 and falls in the cycle after the final sample.

Decomposition:
- Shared package uart_pkg:
  - State encodings (IDLE..WAIT_IDLE).
  - Default CLK_FREQ / BAUD_RATE.
  - Frame constants: DATA_BITS=8, STOP_BITS=1.
- One sub-module: uart_rx_sync, a 2-flop synchronizer.
  - Reset value 1, async active-low reset.
  - Reusable for other asynchronous inputs.

Test Plan:
1. Send 0x50 at 86 cycles/bit, rx_ready=1 -> rx_data=0x50 and rx_valid=1 one cycle after the stop sample; no frame_err or overrun.
2. Stream "Philip Mohr" (11 bytes, 0x50 0x68 0x69 0x6C 0x69 0x70 0x20 0x4D 0x6F 0x68 0x72) back-to-back at 87 cycles/bit, rx_ready=1 -> all 11 bytes delivered in order, no errors.
3. 20-cycle low glitch on idle rx -> START rejects it; rx_valid stays 0, busy returns low, no frame_err.
4. Frame 0xA5 with stop bit forced low, then line held low 300 cycles -> one frame_err pulse, no rx_valid; state stays WAIT_IDLE until rx high, then 0x3C received correctly.
5. Send 0x55 then 0xAA with rx_ready=0 -> rx_data=0x55 held, one overrun pulse at 0xAA completion; after rx_ready=1 for one cycle, rx_valid=0.
6. Assert rst_n low during bit 4 of 0xC3, release, then send 0x12 -> no output for 0xC3; rx_data=0x12 valid; all outputs at reset values while reset is asserted.
